// File: rtl/vga_timing_ctrl_if.sv
// Mode-word configuration handshake between the requester and vga_timing_ctrl.
interface vga_timing_ctrl_if;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic [7:0] cfg_mode;
  logic       cfg_applied;

  modport master (output cfg_valid, cfg_data, input cfg_ready, cfg_mode, cfg_applied);
  modport slave  (input cfg_valid, cfg_data, output cfg_ready, cfg_mode, cfg_applied);
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA frame timing: position counters, syncs, visible flag, frame count and mode-word handoff.
// Define VGA_CFG_FRAME_SYNC_EN to defer mode changes to the next frame boundary.
module vga_timing_ctrl #(
  parameter int H_VIEW   = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_VIEW   = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_ctrl_if.slave  cfg,
  output logic              hsync,
  output logic              vsync,
  output logic              visible,
  output logic [9:0]        hpos,
  output logic [9:0]        vpos,
  output logic              new_line,
  output logic              new_frame,
  output logic [7:0]        frame
);
  localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_BEG = 10'(H_VIEW + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VIEW + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VIEW + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VIEW + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VIEW);
  localparam logic [9:0] V_VIS  = 10'(V_VIEW);

  logic       h_wrap, f_wrap;
  logic [9:0] h_nxt, v_nxt;
  logic       hs_act, vs_act;

  // Flags are decoded from the next counter values so they line up with hpos/vpos.
  assign h_wrap = (hpos == H_LAST);
  assign f_wrap = h_wrap && (vpos == V_LAST);
  assign h_nxt  = h_wrap ? 10'd0 : hpos + 10'd1;
  assign v_nxt  = f_wrap ? 10'd0 : (h_wrap ? vpos + 10'd1 : vpos);
  assign hs_act = (h_nxt >= HS_BEG) && (h_nxt <= HS_END);
  assign vs_act = (v_nxt >= VS_BEG) && (v_nxt <= VS_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos      <= '0;
      vpos      <= '0;
      frame     <= '0;
      hsync     <= ~SYNC_POL;
      vsync     <= ~SYNC_POL;
      visible   <= 1'b1;
      new_line  <= 1'b1;
      new_frame <= 1'b1;
    end else begin
      hpos      <= h_nxt;
      vpos      <= v_nxt;
      frame     <= f_wrap ? frame + 8'd1 : frame;
      hsync     <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync     <= vs_act ? SYNC_POL : ~SYNC_POL;
      visible   <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      new_line  <= (h_nxt == 10'd0);
      new_frame <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

  logic [7:0] mode_q;
  logic       applied_q;
  assign cfg.cfg_mode    = mode_q;
  assign cfg.cfg_applied = applied_q;

`ifdef VGA_CFG_FRAME_SYNC_EN
  logic       full;
  logic [7:0] pend;

  // Accept needs an empty slot and apply needs a full one, so they never collide;
  // a word taken in the wrap cycle therefore waits for the following boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full      <= 1'b0;
      pend      <= '0;
      mode_q    <= '0;
      applied_q <= 1'b0;
    end else begin
      applied_q <= 1'b0;
      if (full && f_wrap) begin
        mode_q    <= pend;
        full      <= 1'b0;
        applied_q <= 1'b1;
      end else if (cfg.cfg_valid && !full) begin
        pend <= cfg.cfg_data;
        full <= 1'b1;
      end
    end
  end

  assign cfg.cfg_ready = ~full;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= '0;
      applied_q <= 1'b0;
    end else begin
      applied_q <= cfg.cfg_valid;
      if (cfg.cfg_valid) mode_q <= cfg.cfg_data;
    end
  end

  assign cfg.cfg_ready = 1'b1;
`endif
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl on a shrunken 10x8 raster (80 clocks/frame).
module tb_vga_timing_ctrl;
  localparam int HV = 4, HF = 2, HS = 2, HB = 2;
  localparam int VV = 3, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam bit POL = 1'b0;

  logic clk = 1'b0;
  logic reset;
  logic hsync, vsync, visible, new_line, new_frame;
  logic [9:0] hpos, vpos;
  logic [7:0] frame;

  vga_timing_ctrl_if cfg ();

  vga_timing_ctrl #(
    .H_VIEW(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VIEW(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .reset(reset), .cfg(cfg),
    .hsync(hsync), .vsync(vsync), .visible(visible),
    .hpos(hpos), .vpos(vpos), .new_line(new_line), .new_frame(new_frame),
    .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [9:0] hp, vp;
    logic       hs, vs, vis, nl, nf;
    logic [7:0] fr;
  } probe_t;
  probe_t probes[$];

  int n_chk = 0, n_pass = 0;
  int t;
  logic [7:0] m_mode, pend;
  logic       m_applied, pend_v;
  int         due;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, exp);
  endtask

  task automatic add_probe(input int tt, input int hp, input int vp, input int hs, input int vs,
                           input int vis, input int nl, input int nf, input int fr);
    probe_t p;
    p.t = tt; p.hp = 10'(hp); p.vp = 10'(vp);
    p.hs = 1'(hs); p.vs = 1'(vs); p.vis = 1'(vis); p.nl = 1'(nl); p.nf = 1'(nf);
    p.fr = 8'(fr);
    probes.push_back(p);
  endtask

  function automatic logic m_ready();
`ifdef VGA_CFG_FRAME_SYNC_EN
    return !pend_v;
`else
    return 1'b1;
`endif
  endfunction

  // Reference view of cycle t after reset release, straight from the raster arithmetic.
  function automatic logic [42:0] exp_vec();
    int hp, vp, fr;
    logic hs, vs, vis, nl, nf;
    hp  = t % HT;
    vp  = (t / HT) % VT;
    fr  = (t / FT) % 256;
    hs  = (hp >= HV + HF && hp < HV + HF + HS) ? POL : ~POL;
    vs  = (vp >= VV + VF && vp < VV + VF + VS) ? POL : ~POL;
    vis = (hp < HV) && (vp < VV);
    nl  = (hp == 0);
    nf  = (hp == 0) && (vp == 0);
    return {10'(hp), 10'(vp), hs, vs, vis, nl, nf, 8'(fr), m_mode, m_applied, m_ready()};
  endfunction

  logic [42:0] dut_vec;
  assign dut_vec = {hpos, vpos, hsync, vsync, visible, new_line, new_frame, frame,
                    cfg.cfg_mode, cfg.cfg_applied, cfg.cfg_ready};

  task automatic check_all();
    chk("cycle", 64'(dut_vec), 64'(exp_vec()));
    foreach (probes[i])
      if (probes[i].t == t)
        chk("probe", 64'({hpos, vpos, hsync, vsync, visible, new_line, new_frame, frame}),
            64'({probes[i].hp, probes[i].vp, probes[i].hs, probes[i].vs, probes[i].vis,
                 probes[i].nl, probes[i].nf, probes[i].fr}));
  endtask

  task automatic model_reset();
    t = 0; m_mode = '0; m_applied = 1'b0; pend_v = 1'b0; pend = '0; due = 0;
  endtask

  // A word takes effect at the first frame start that is at least two states after its accept cycle.
  task automatic model_step(input logic acc, input logic [7:0] d);
    int t_old;
    t_old = t;
    t++;
`ifdef VGA_CFG_FRAME_SYNC_EN
    m_applied = 1'b0;
    if (pend_v && t == due) begin
      m_mode = pend; pend_v = 1'b0; m_applied = 1'b1;
    end
    if (acc) begin
      pend_v = 1'b1; pend = d; due = ((t_old + 1) / FT + 1) * FT;
    end
`else
    m_applied = acc;
    if (acc) m_mode = d;
`endif
  endtask

  task automatic tick(input logic v, input logic [7:0] d, output logic acc);
    cfg.cfg_valid = v;
    cfg.cfg_data  = d;
    acc = v && m_ready();
    @(posedge clk);
    model_step(acc, d);
    #1 check_all();
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic run_to(input int target);
    logic a;
    while (t < target) tick(1'b0, 8'h00, a);
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, "_pos"}, 64'({hpos, vpos}), 64'(0));
    chk({nm, "_sync"}, 64'({hsync, vsync}), 64'({~POL, ~POL}));
    chk({nm, "_flags"}, 64'({visible, new_line, new_frame}), 64'(3'b111));
    chk({nm, "_frame"}, 64'(frame), 64'(0));
    chk({nm, "_cfg"}, 64'({cfg.cfg_mode, cfg.cfg_applied, cfg.cfg_ready}), 64'({8'h00, 1'b0, 1'b1}));
  endtask

  initial begin
    logic a, off_v;
    logic [7:0] off_d;
    int k, guard;

    add_probe(0,     0, 0, 1, 1, 1, 1, 1, 0);
    add_probe(1,     1, 0, 1, 1, 1, 0, 0, 0);
    add_probe(4,     4, 0, 1, 1, 0, 0, 0, 0);
    add_probe(6,     6, 0, 0, 1, 0, 0, 0, 0);
    add_probe(7,     7, 0, 0, 1, 0, 0, 0, 0);
    add_probe(8,     8, 0, 1, 1, 0, 0, 0, 0);
    add_probe(10,    0, 1, 1, 1, 1, 1, 0, 0);
    add_probe(23,    3, 2, 1, 1, 1, 0, 0, 0);
    add_probe(33,    3, 3, 1, 1, 0, 0, 0, 0);
    add_probe(45,    5, 4, 1, 0, 0, 0, 0, 0);
    add_probe(56,    6, 5, 0, 0, 0, 0, 0, 0);
    add_probe(60,    0, 6, 1, 1, 0, 1, 0, 0);
    add_probe(79,    9, 7, 1, 1, 0, 0, 0, 0);
    add_probe(80,    0, 0, 1, 1, 1, 1, 1, 1);
    add_probe(160,   0, 0, 1, 1, 1, 1, 1, 2);
    add_probe(20479, 9, 7, 1, 1, 0, 0, 0, 255);
    add_probe(20480, 0, 0, 1, 1, 1, 1, 1, 0);

    model_reset();
    reset = 1'b1;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = 8'h00;
    #12 rst_chk("rst_init");
    @(negedge clk);
    reset = 1'b0;
    check_all();
    tick(1'b0, 8'h00, a);
    chk("first_step_hpos", 64'(hpos), 64'(1));

`ifdef VGA_CFG_FRAME_SYNC_EN
    run_to(23);
    tick(1'b1, 8'hA5, a);
    chk("acc_ready_low", 64'(cfg.cfg_ready), 64'(0));
    while (t < 79) tick(1'b1, 8'h3C, a);
    chk("mode_held", 64'(cfg.cfg_mode), 64'(8'h00));
    tick(1'b1, 8'h3C, a);
    chk("apply_a5", 64'({cfg.cfg_mode, cfg.cfg_applied, new_frame, cfg.cfg_ready}),
        64'({8'hA5, 1'b1, 1'b1, 1'b1}));
    tick(1'b1, 8'h3C, a);
    chk("acc_3c", 64'(cfg.cfg_ready), 64'(0));
    run_to(159);
    chk("mode_still_a5", 64'(cfg.cfg_mode), 64'(8'hA5));
    run_to(160);
    chk("apply_3c", 64'({cfg.cfg_mode, cfg.cfg_applied}), 64'({8'h3C, 1'b1}));
    run_to(239);
    tick(1'b1, 8'h77, a);
    chk("wrap_hold", 64'({cfg.cfg_mode, cfg.cfg_applied, new_frame}), 64'({8'h3C, 1'b0, 1'b1}));
    run_to(320);
    chk("apply_77", 64'({cfg.cfg_mode, cfg.cfg_applied}), 64'({8'h77, 1'b1}));
`else
    run_to(23);
    tick(1'b1, 8'h5A, a);
    chk("direct_5a", 64'({cfg.cfg_mode, cfg.cfg_applied, cfg.cfg_ready}), 64'({8'h5A, 1'b1, 1'b1}));
    tick(1'b0, 8'h00, a);
    chk("direct_pulse_end", 64'({cfg.cfg_mode, cfg.cfg_applied}), 64'({8'h5A, 1'b0}));
    run_to(239);
    tick(1'b1, 8'h77, a);
    chk("direct_77", 64'({cfg.cfg_mode, cfg.cfg_applied}), 64'({8'h77, 1'b1}));
`endif

    // Random requester that holds each offer until it is taken.
    off_v = 1'b0;
    off_d = 8'h00;
    while (t < 20500) begin
      if (!off_v && $urandom_range(0, 2) == 0) begin
        off_v = 1'b1;
        off_d = 8'($urandom);
      end
      tick(off_v, off_d, a);
      if (a) off_v = 1'b0;
    end

    k = t / FT + 2;
    run_to(k * FT + 3);
    guard = 0;
    a = 1'b0;
    while (!a && guard < 200) begin
      tick(1'b1, 8'h11, a);
      guard++;
    end
    chk("acc_11", 64'(a), 64'(1));
    run_to(k * FT + 45);
    #2 reset = 1'b1;
    #1 rst_chk("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_chk("rst_hold");
    reset = 1'b0;
    model_reset();
    check_all();
    tick(1'b0, 8'h00, a);
    chk("post_rst_hpos", 64'(hpos), 64'(1));
    run_to(FT);
    chk("post_rst_no_apply", 64'({cfg.cfg_mode, cfg.cfg_applied, new_frame}), 64'({8'h00, 1'b0, 1'b1}));
    run_to(FT + 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Frame timing controller for the VGA demo datapath. It generates horizontal and vertical position counters, sync pulses and the visible-area flag that sequence pixel generation. It also owns a one-deep configuration handshake that hands a new pattern mode word to the datapath only at a frame boundary, so a mode change never tears mid-frame. It sits between the top-level wrapper's input pins and the pattern generator.

## Interface

Parameters:
- H_VIEW, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VIEW, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active sync level (0 = active-low)

Ports:
- clk  in  1  pixel clock; the block's only clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  requester offers cfg_data
- cfg_data  in  8  new mode word
- cfg_ready  out  1  pending slot empty; transfer when cfg_valid && cfg_ready
- cfg_mode  out  8  active mode word, driven to the datapath
- cfg_applied  out  1  one-clock pulse when cfg_mode takes a new value
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- visible  out  1  high when hpos < H_VIEW and vpos < V_VIEW
- hpos  out  10  current column, 0..H_TOTAL-1 (H_TOTAL = 800 by default)
- vpos  out  10  current line, 0..V_TOTAL-1 (V_TOTAL = 525 by default)
- new_line  out  1  high for the cycle where hpos == 0
- new_frame  out  1  high for the cycle where hpos == 0 and vpos == 0
- frame  out  8  frame count, increments at every frame wrap, 255 wraps to 0

## Operation

- hpos increments every clk and wraps H_TOTAL-1 -> 0.
- vpos increments on the hpos wrap and wraps V_TOTAL-1 -> 0.
- hsync is active for hpos in [H_VIEW+H_FRONT, H_VIEW+H_FRONT+H_SYNC-1]. With defaults, that is 656..751.
- vsync is active for vpos in [V_VIEW+V_FRONT, V_VIEW+V_FRONT+V_SYNC-1]. With defaults, that is 490..491.
- All outputs are registered.
- hsync, vsync, visible, new_line and new_frame always describe the hpos/vpos values presented in the same cycle. They are decoded from next-state counter values, not delayed by one clock.
- Configuration path: a pending register (8 bits) plus a full flag.
  - Accept: on cfg_valid && cfg_ready, store cfg_data and set full. cfg_ready goes low the next cycle.
  - Apply: in the clock edge that moves the counters to (0,0), if full was set at the start of that cycle:
    - cfg_mode <= pending, full is cleared, and cfg_applied pulses in the same cycle as new_frame.
    - cfg_ready returns high in that same cycle.
  - A word accepted in the wrap cycle itself is held until the following frame boundary.
  - While full, cfg_valid is ignored and the requester must hold cfg_data.
- Reset (asynchronous, any time, including mid-frame or mid-handshake):
  - hpos = 0, vpos = 0, frame = 0, cfg_mode = 0.
  - Pending word is discarded; full = 0, cfg_ready = 1.
  - hsync and vsync are inactive (= ~SYNC_POL).
  - visible = 1, new_line = 1, new_frame = 1, cfg_applied = 0.
  - After release, counting resumes from (0,0) on the first clk edge.

## Timing

- Line = H_TOTAL clocks; frame = H_TOTAL × V_TOTAL clocks (420000 by default).
- new_line pulses every H_TOTAL clocks; new_frame every H_TOTAL × V_TOTAL clocks.
- Config latency: from accept to cfg_mode update is between 1 and H_TOTAL × V_TOTAL clocks, always landing on a frame boundary.
- Maximum configuration throughput is one word per frame.

## Configuration

- Macro VGA_CFG_FRAME_SYNC_EN.
  - Defined: frame-synchronous apply, exactly as described under Operation.
  - Undefined: the pending register and full flag are removed and cfg_ready is tied to 1. An accepted word appears on cfg_mode the next clk, with cfg_applied pulsing in that cycle, regardless of counter position.
- Sync, counter and frame behaviour are identical in both builds.

## Test plan

- Reset release -> hpos = 0, vpos = 0, hsync = vsync = 1, visible = 1, new_frame = 1, cfg_mode = 0, cfg_ready = 1; then hpos = 1 one clock later.
- Run one line -> hsync low exactly for hpos 656..751 (96 clocks); visible falls at hpos 640; new_line pulses every 800 clocks.
- Run two frames -> vsync low only on lines 490..491; new_frame spacing 420000 clocks; frame goes 0 -> 1 -> 2. Preload to 255 -> next wrap gives 0.
- Macro defined: offer 0xA5 at (100,200) -> cfg_ready low the next clock. A second offer of 0x3C is held off. cfg_mode stays 0x00 until (0,0), then becomes 0xA5 with cfg_applied = new_frame = 1 and cfg_ready = 1. 0x3C is accepted next and applied one frame later.
- Offer 0x77 in the wrap cycle -> cfg_mode unchanged at that boundary; becomes 0x77 one full frame later.
- Assert reset at (300,250) with 0x11 pending -> all outputs return to reset values. After release, no cfg_applied at the next frame boundary and cfg_mode = 0.
- Macro undefined: offer 0x5A mid-line -> cfg_mode = 0x5A and cfg_applied = 1 on the next clock; cfg_ready constant 1.
